tmds_encoder: RTL and testbench
===============================

# tmds_encoder

- Pixel-domain TMDS encoder directly downstream of `syncgen`/`ptngen`.
- Takes 8-bit RGB plus display enable and sync levels each pixel clock, and produces three 10-bit DVI/TMDS symbols per clock for a later 10:1 serializer.
- Channel 0 carries blue and sync, channel 1 green, channel 2 red.
- The block's output replaces the bench's raw RGB file dump as the monitored stream.

## Interface
- `LATENCY`, default 2: pixel-clock cycles from input sample to symbol output. Fixed by design; exported read-only for benches.
- `PCK`  input  1  pixel clock. All logic on its rising edge.
- `RST`  input  1  reset, synchronous, active-low (0 = reset).
- `VGA_R`  input  8  red pixel, from `ptngen`.
- `VGA_G`  input  8  green pixel.
- `VGA_B`  input  8  blue pixel.
- `VGA_DISPLAY_EN`  input  1  active video, from `syncgen`.
- `VGA_HSYNC`  input  1  horizontal sync level. Passed as-is; polarity is not interpreted.
- `VGA_VSYNC`  input  1  vertical sync level.
- `TMDS_CH0`  output  10  blue/sync symbol, LSB transmitted first.
- `TMDS_CH1`  output  10  green symbol.
- `TMDS_CH2`  output  10  red symbol.

## Operation
**Control period** (`VGA_DISPLAY_EN`=0)
- Each channel emits a control token selected by {C1,C0}:
  - 00 → 10'h354
  - 01 → 10'h0AB
  - 10 → 10'h154
  - 11 → 10'h2AB
- CH0 uses {C1,C0} = {`VGA_VSYNC`,`VGA_HSYNC`}.
- CH1 and CH2 use {0,0}.
- Each channel's running disparity `cnt` is cleared to 0.

**Data period, stage 1** (transition minimisation, registered)
- N1 = popcount(D).
- If N1>4 or (N1==4 and D[0]==0), use XNOR: q_m[0]=D[0], q_m[i]=~(q_m[i-1]^D[i]), q_m[8]=0.
- Otherwise use XOR: q_m[i]=q_m[i-1]^D[i], q_m[8]=1.

**Data period, stage 2** (DC balance, registered)
- n1/n0 = ones/zeros of q_m[7:0].
- If cnt==0 or n1==n0:
  - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
  - cnt += q_m[8] ? (n1−n0) : (n0−n1).
- Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
  - out = {1, q_m[8], ~q_m[7:0]}.
  - cnt += 2·q_m[8] + (n0−n1).
- Else:
  - out = {0, q_m[8], q_m[7:0]}.
  - cnt += (n1−n0) − 2·(~q_m[8]).

**Arithmetic**
- `cnt` is 5-bit signed two's complement. Its reachable range of ±10 never wraps.
- Popcounts are 4-bit unsigned. Differences are evaluated in 6-bit signed.

**Sideband pipeline**
- `VGA_DISPLAY_EN`, `VGA_HSYNC` and `VGA_VSYNC` travel with the pixel through every stage, so data/control selection and tokens stay aligned with their pixel.

## Timing
- Reset: with `RST`=0 at a rising edge, all pipeline registers clear, and all three outputs are 10'h354 from the next edge onward. All `cnt` = 0.
- Reset mid-line: identical. The first symbols after release are 10'h354 until valid input propagates, i.e. for `LATENCY` cycles.
- Latency: input sampled at edge k appears on the outputs after edge k+`LATENCY`. Throughput is one symbol per channel per clock, with no stalls.
- Enable 1→0: the first control token appears exactly `LATENCY` cycles after the falling enable. `cnt` is 0 for the first data pixel of the next line.
- Enable 0→1: the first data symbol is encoded with cnt=0.
- Sync changes during active video are carried but have no effect on the output.

## Configuration
- Macro `TMDS_GUARD_BAND_EN` inserts HDMI video guard bands before each active period.
- When defined:
  - Inputs pass through 2 extra delay registers (`LATENCY` = 4), so each enable rising edge is known 2 cycles ahead.
  - The 2 control symbols immediately preceding the first data symbol are replaced by guard band: CH0 = 10'h2CC, CH1 = 10'h133, CH2 = 10'h2CC.
  - If blanking is shorter than 2 cycles, only the available control slots are replaced.
- When undefined:
  - `LATENCY` = 2.
  - No guard band is inserted; control tokens run right up to data.

## Structure
- Package `tmds_pkg` holds:
  - the four control-token constants
  - the three guard-band constants
  - the `LATENCY` value, derived from the macro
  - the 5-bit disparity type
- Sub-module `tmds_enc_ch`: one channel (stages 1–2, disparity counter, token mux), with ports D[7:0], DE, C1, C0 → Q[9:0].
- `tmds_encoder` instantiates three of them plus the sideband and guard-band delay logic.

## Test plan
1. Hold `RST`=0 for 3 cycles with random inputs → all channels read 10'h354; after release they stay 10'h354 for `LATENCY` cycles.
2. DE=0 with {V,H} = 00, 01, 10, 11 → CH0 shows 10'h354, 10'h0AB, 10'h154, 10'h2AB after `LATENCY` cycles, while CH1 and CH2 stay 10'h354.
3. DE=1 with B=8'h00 held for 4 pixels from cnt=0 → CH0 shows 10'h100, 10'h3FF, 10'h100, 10'h3FF.
4. DE=1 with R=8'hFF as the first pixel after blanking → CH2 shows 10'h200; a blanking gap then a second line starting with 8'hFF again gives 10'h200 (cnt cleared).
5. Random 640-pixel lines checked against a reference-model decode → every symbol decodes to its input byte, and the running disparity never exceeds ±10.
6. With `TMDS_GUARD_BAND_EN` and blanking ≥2 → the two symbols before the first data symbol are 10'h2CC/10'h133/10'h2CC, and data is delayed by 4 cycles.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared constants, types and helpers for the TMDS pixel encoder.
// TMDS_GUARD_BAND_EN selects the guard-band build, which raises LATENCY from 2 to 4.
package tmds_pkg;

  localparam logic [9:0] CtrlTok00 = 10'h354;
  localparam logic [9:0] CtrlTok01 = 10'h0AB;
  localparam logic [9:0] CtrlTok10 = 10'h154;
  localparam logic [9:0] CtrlTok11 = 10'h2AB;

  localparam logic [9:0] GuardCh0 = 10'h2CC;
  localparam logic [9:0] GuardCh1 = 10'h133;
  localparam logic [9:0] GuardCh2 = 10'h2CC;

`ifdef TMDS_GUARD_BAND_EN
  localparam int unsigned LATENCY = 4;
`else
  localparam int unsigned LATENCY = 2;
`endif

  typedef logic signed [4:0] disp_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       de;
    logic       hs;
    logic       vs;
  } pix_t;

  function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
    logic [9:0] tok;
    unique case ({c1, c0})
      2'b00:   tok = CtrlTok00;
      2'b01:   tok = CtrlTok01;
      2'b10:   tok = CtrlTok10;
      default: tok = CtrlTok11;
    endcase
    return tok;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Pixel-side bundle: RGB, enable and syncs in, three TMDS symbols out.
interface tmds_encoder_if;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       VGA_DISPLAY_EN;
  logic       VGA_HSYNC;
  logic       VGA_VSYNC;
  logic [9:0] TMDS_CH0;
  logic [9:0] TMDS_CH1;
  logic [9:0] TMDS_CH2;

  modport master (
    output VGA_R, VGA_G, VGA_B, VGA_DISPLAY_EN, VGA_HSYNC, VGA_VSYNC,
    input  TMDS_CH0, TMDS_CH1, TMDS_CH2
  );

  modport slave (
    input  VGA_R, VGA_G, VGA_B, VGA_DISPLAY_EN, VGA_HSYNC, VGA_VSYNC,
    output TMDS_CH0, TMDS_CH1, TMDS_CH2
  );
endinterface

// File: rtl/tmds_enc_ch.sv
// One TMDS channel: transition minimisation, then DC balance with a running disparity.
// GB replaces the control token with GuardToken in the current control slot.
module tmds_enc_ch
  import tmds_pkg::*;
#(
  parameter logic [9:0] GuardToken = 10'h2CC
) (
  input  logic       PCK,
  input  logic       RST,
  input  logic [7:0] D,
  input  logic       DE,
  input  logic       C1,
  input  logic       C0,
  input  logic       GB,
  output logic [9:0] Q
);

  logic [8:0] qm_d, qm_q;
  logic       de_q;
  logic [1:0] c_q;
  logic [3:0] n1_in;

  always_comb begin
    logic use_xnor;
    n1_in    = popcount8(D);
    use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !D[0]);
    qm_d     = '0;
    qm_d[0]  = D[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ D[i]) : (qm_d[i-1] ^ D[i]);
    end
    qm_d[8] = ~use_xnor;
  end

  always_ff @(posedge PCK) begin
    if (!RST) begin
      qm_q <= '0;
      de_q <= 1'b0;
      c_q  <= 2'b00;
    end else begin
      qm_q <= qm_d;
      de_q <= DE;
      c_q  <= {C1, C0};
    end
  end

  logic [3:0]        n1, n0;
  logic signed [5:0] diff, cnt6, two_qm8, two_nqm8, sum;
  logic [9:0]        q_d, q_q;
  disp_t             cnt_d, cnt_q;
  logic              cnt_pos, cnt_neg;

  always_comb begin
    n1       = popcount8(qm_q[7:0]);
    n0       = 4'd8 - n1;
    diff     = $signed({2'b00, n1}) - $signed({2'b00, n0});
    cnt6     = {cnt_q[4], cnt_q};
    two_qm8  = {3'b000, qm_q[8], 2'b00} >>> 1;
    two_nqm8 = {3'b000, ~qm_q[8], 2'b00} >>> 1;
    cnt_pos  = !cnt_q[4] && (cnt_q != '0);
    cnt_neg  = cnt_q[4];
    sum      = '0;
    q_d      = q_q;
    cnt_d    = cnt_q;
    if (!de_q) begin
      q_d   = GB ? GuardToken : ctrl_token(c_q[1], c_q[0]);
      cnt_d = '0;
    end else if ((cnt_q == '0) || (n1 == n0)) begin
      q_d   = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      sum   = qm_q[8] ? (cnt6 + diff) : (cnt6 - diff);
      cnt_d = disp_t'(sum[4:0]);
    end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
      q_d   = {1'b1, qm_q[8], ~qm_q[7:0]};
      sum   = cnt6 + two_qm8 - diff;
      cnt_d = disp_t'(sum[4:0]);
    end else begin
      q_d   = {1'b0, qm_q[8], qm_q[7:0]};
      sum   = cnt6 + diff - two_nqm8;
      cnt_d = disp_t'(sum[4:0]);
    end
  end

  always_ff @(posedge PCK) begin
    if (!RST) begin
      q_q   <= CtrlTok00;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/tmds_encoder.sv
// Three-channel TMDS encoder: CH0 blue+sync, CH1 green, CH2 red.
// With TMDS_GUARD_BAND_EN, two look-ahead registers let guard bands precede active video.
module tmds_encoder
  import tmds_pkg::*;
(
  input logic           PCK,
  input logic           RST,
  tmds_encoder_if.slave vga
);

  pix_t pix_in, pix;
  logic guard;

  always_comb begin
    pix_in    = '0;
    pix_in.r  = vga.VGA_R;
    pix_in.g  = vga.VGA_G;
    pix_in.b  = vga.VGA_B;
    pix_in.de = vga.VGA_DISPLAY_EN;
    pix_in.hs = vga.VGA_HSYNC;
    pix_in.vs = vga.VGA_VSYNC;
  end

`ifdef TMDS_GUARD_BAND_EN
  pix_t       d1_q, d2_q;
  logic       de_s1_q;
  logic [2:0] vld_q;

  // de_s1_q mirrors the channels' stage-1 enable; vld_q keeps reset-fill slots as plain tokens.
  always_ff @(posedge PCK) begin
    if (!RST) begin
      d1_q    <= '0;
      d2_q    <= '0;
      de_s1_q <= 1'b0;
      vld_q   <= 3'b000;
    end else begin
      d1_q    <= pix_in;
      d2_q    <= d1_q;
      de_s1_q <= d2_q.de;
      vld_q   <= {vld_q[1:0], 1'b1};
    end
  end

  assign pix   = d2_q;
  assign guard = vld_q[2] && !de_s1_q && (d2_q.de || d1_q.de);
`else
  assign pix   = pix_in;
  assign guard = 1'b0;
`endif

  tmds_enc_ch #(
    .GuardToken(GuardCh0)
  ) u_ch0 (
    .PCK(PCK),
    .RST(RST),
    .D  (pix.b),
    .DE (pix.de),
    .C1 (pix.vs),
    .C0 (pix.hs),
    .GB (guard),
    .Q  (vga.TMDS_CH0)
  );

  tmds_enc_ch #(
    .GuardToken(GuardCh1)
  ) u_ch1 (
    .PCK(PCK),
    .RST(RST),
    .D  (pix.g),
    .DE (pix.de),
    .C1 (1'b0),
    .C0 (1'b0),
    .GB (guard),
    .Q  (vga.TMDS_CH1)
  );

  tmds_enc_ch #(
    .GuardToken(GuardCh2)
  ) u_ch2 (
    .PCK(PCK),
    .RST(RST),
    .D  (pix.r),
    .DE (pix.de),
    .C1 (1'b0),
    .C0 (1'b0),
    .GB (guard),
    .Q  (vga.TMDS_CH2)
  );

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed bench for tmds_encoder: hand-computed symbols plus decode and disparity checks.
module tb_tmds_encoder;
  import tmds_pkg::LATENCY;

  typedef struct {
    logic [7:0] r, g, b;
    logic       de, hs, vs;
    logic [2:0] ex;
    logic [9:0] e0, e1, e2;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tmds_encoder_if vga ();

  tmds_encoder dut (
    .PCK(clk),
    .RST(rst_n),
    .vga(vga)
  );

  logic [9:0] tok_ref[4]   = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  logic [9:0] guard_ref[3] = '{10'h2CC, 10'h133, 10'h2CC};

  vec_t pend[$];
  bit   mon_on = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   disp[3];
  vec_t mv;
  bit   mgb;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic int ones10(input logic [9:0] s);
    int n = 0;
    for (int i = 0; i < 10; i++) n += int'(s[i]);
    return n;
  endfunction

  task automatic chan_chk(input int ch, input logic [9:0] s, input logic [7:0] px,
                          input logic [1:0] ctl, input bit ex, input logic [9:0] e,
                          input bit de, input bit gb);
    if (ex) check($sformatf("ch%0d exact", ch), s, e);
    if (de) begin
      if (!ex) check($sformatf("ch%0d decode", ch), {2'b00, decode(s)}, {2'b00, px});
      disp[ch] += 2 * ones10(s) - 10;
      check($sformatf("ch%0d disparity", ch),
            {9'd0, (disp[ch] <= 10 && disp[ch] >= -10)}, 10'd1);
    end else begin
      if (!ex) check($sformatf("ch%0d control", ch), s, gb ? guard_ref[ch] : tok_ref[ctl]);
      disp[ch] = 0;
    end
  endtask

  // Output seen at a negedge belongs to the vector driven LATENCY cycles earlier.
  always @(negedge clk) begin
    if (mon_on) begin
      if (pend.size() > LATENCY) begin
        mv = pend.pop_front();
`ifdef TMDS_GUARD_BAND_EN
        mgb = pend[0].de || pend[1].de;
`else
        mgb = 1'b0;
`endif
        chan_chk(0, vga.TMDS_CH0, mv.b, {mv.vs, mv.hs}, mv.ex[0], mv.e0, mv.de, mgb);
        chan_chk(1, vga.TMDS_CH1, mv.g, 2'b00, mv.ex[1], mv.e1, mv.de, mgb);
        chan_chk(2, vga.TMDS_CH2, mv.r, 2'b00, mv.ex[2], mv.e2, mv.de, mgb);
      end else begin
        check("fill ch0", vga.TMDS_CH0, 10'h354);
        check("fill ch1", vga.TMDS_CH1, 10'h354);
        check("fill ch2", vga.TMDS_CH2, 10'h354);
      end
    end
  end

  function automatic vec_t mk(input logic [7:0] r, g, b, input logic de, hs, vs);
    vec_t v;
    v.r = r; v.g = g; v.b = b; v.de = de; v.hs = hs; v.vs = vs;
    v.ex = 3'b000; v.e0 = '0; v.e1 = '0; v.e2 = '0;
    return v;
  endfunction

  task automatic set_inputs(input vec_t v);
    vga.VGA_R = v.r;
    vga.VGA_G = v.g;
    vga.VGA_B = v.b;
    vga.VGA_DISPLAY_EN = v.de;
    vga.VGA_HSYNC = v.hs;
    vga.VGA_VSYNC = v.vs;
  endtask

  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      rst_n  = 1'b1;
      mon_on = 1'b1;
    end
    set_inputs(v);
    pend.push_back(v);
  endtask

  function automatic vec_t rnd_vec(input logic de);
    return mk(8'($urandom), 8'($urandom), 8'($urandom), de, 1'($urandom), 1'($urandom));
  endfunction

  task automatic blanks(input int n);
    for (int i = 0; i < n; i++) drive(rnd_vec(1'b0));
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) drive(rnd_vec(1'b1));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    mon_on = 1'b0;
    pend.delete();
    for (int c = 0; c < 3; c++) disp[c] = 0;
    set_inputs(rnd_vec(1'($urandom)));
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      set_inputs(rnd_vec(1'($urandom)));
      @(negedge clk);
      check("reset ch0", vga.TMDS_CH0, 10'h354);
      check("reset ch1", vga.TMDS_CH1, 10'h354);
      check("reset ch2", vga.TMDS_CH2, 10'h354);
    end
  endtask

  logic [7:0] ga[4]  = '{8'h55, 8'hAA, 8'h55, 8'hAA};
  logic [9:0] e0a[4] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
  logic [9:0] e1a[4] = '{10'h133, 10'h233, 10'h133, 10'h233};

  initial begin
    vec_t v;
    for (int c = 0; c < 3; c++) disp[c] = 0;
    set_inputs(rnd_vec(1'b1));
    do_reset(3);

    // Control tokens for each {V,H}; CH1/CH2 stay on the 00 token.
    for (int i = 0; i < 4; i++) begin
      v = mk(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, i[0], i[1]);
      v.ex = 3'b111; v.e0 = tok_ref[i]; v.e1 = 10'h354; v.e2 = 10'h354;
      drive(v);
    end
    blanks(3);

    // Line A: B=00 alternates 100/3FF, G=55/AA balanced, R=FF first gives 200; syncs toggle.
    for (int i = 0; i < 4; i++) begin
      v = mk((i == 0) ? 8'hFF : 8'($urandom), ga[i], 8'h00, 1'b1, i[0], i[1]);
      v.ex = (i == 0) ? 3'b111 : 3'b011;
      v.e0 = e0a[i]; v.e1 = e1a[i]; v.e2 = 10'h200;
      drive(v);
    end
    pixels(4);
    blanks(3);

    // Line B: disparity cleared by blanking, so first-pixel symbols repeat.
    v = mk(8'hFF, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    v.ex = 3'b111; v.e0 = 10'h1FF; v.e1 = 10'h100; v.e2 = 10'h200;
    drive(v);
    pixels(6);

    // One-cycle blanking, then two full random lines.
    blanks(1);
    pixels(8);
    for (int l = 0; l < 2; l++) begin
      blanks(20);
      pixels(640);
    end

    // Reset in the middle of a line, released straight into active video.
    do_reset(2);
    pixels(10);
    blanks(5);
    pixels(10);
    blanks(LATENCY + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
